// File: rtl/wb_pkg.sv
// Shared Wishbone B3 constants and elaboration-time helpers for the bus fabric.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  // Ceiling log2; clog2(1) == 0. Only used on constants at elaboration.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/arb_rr.sv
// Combinational round-robin picker: lowest requester strictly above the last
// one-hot grant, otherwise the lowest requester overall (wrap-around).
module arb_rr #(
  parameter int N = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [N-1:0] i_last,
  output logic [N-1:0] o_gnt,
  output logic         o_vld
);

  logic [N-1:0] w_mask_hi;
  logic [N-1:0] w_req_hi;
  logic [N-1:0] w_pick_hi;
  logic [N-1:0] w_pick_any;

  always_comb begin
    logic w_seen;
    w_mask_hi = '0;
    w_seen    = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_mask_hi[i] = w_seen;
      w_seen       = w_seen | i_last[i];
    end
  end

  assign w_req_hi   = i_req & w_mask_hi;
  // x & -x isolates the lowest set bit.
  assign w_pick_hi  = w_req_hi & (~w_req_hi + N'(1));
  assign w_pick_any = i_req & (~i_req + N'(1));

  assign o_gnt = (|w_req_hi) ? w_pick_hi : w_pick_any;
  assign o_vld = |i_req;

endmodule

// File: rtl/wb_arbiter_rr.sv
// Wishbone B3 N-master to 1-slave arbiter: round-robin, grant held for the whole
// cyc, optional stall watchdog that forces an error and releases the bus.
module wb_arbiter_rr
  import wb_pkg::*;
#(
  parameter int MASTERS    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 0,
  localparam int SEL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [ADDR_WIDTH*MASTERS-1:0]    m_adr_i,
  input  logic [DATA_WIDTH*MASTERS-1:0]    m_dat_i,
  input  logic [MASTERS-1:0]               m_cyc_i,
  input  logic [MASTERS-1:0]               m_stb_i,
  input  logic [MASTERS-1:0]               m_we_i,
  input  logic [SEL_WIDTH*MASTERS-1:0]     m_sel_i,
  input  logic [3*MASTERS-1:0]             m_cti_i,
  input  logic [2*MASTERS-1:0]             m_bte_i,
  output logic [DATA_WIDTH-1:0]            m_dat_o,
  output logic [MASTERS-1:0]               m_ack_o,
  output logic [MASTERS-1:0]               m_err_o,
  output logic [MASTERS-1:0]               m_rty_o,
  output logic [ADDR_WIDTH-1:0]            s_adr_o,
  output logic [DATA_WIDTH-1:0]            s_dat_o,
  output logic                             s_cyc_o,
  output logic                             s_stb_o,
  output logic                             s_we_o,
  output logic [SEL_WIDTH-1:0]             s_sel_o,
  output logic [2:0]                       s_cti_o,
  output logic [1:0]                       s_bte_o,
  input  logic [DATA_WIDTH-1:0]            s_dat_i,
  input  logic                             s_ack_i,
  input  logic                             s_err_i,
  input  logic                             s_rty_i,
  output logic [MASTERS-1:0]               grant_o
);

  localparam int                 CW        = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;
  localparam logic               WD_EN     = (TIMEOUT > 0);
  localparam logic [CW-1:0]      WD_LIM    = CW'(TIMEOUT);
  localparam logic [MASTERS-1:0] LAST_INIT = MASTERS'(1) << (MASTERS - 1);

  logic [MASTERS-1:0] r_grant;
  logic [MASTERS-1:0] r_last;
  logic [CW-1:0]      r_cnt;

  logic [MASTERS-1:0] w_arb_gnt;
  logic               w_arb_vld;
  logic               w_held;
  logic               w_stb_g;
  logic               w_term;
  logic               w_expire;

  logic [ADDR_WIDTH-1:0] w_adr;
  logic [DATA_WIDTH-1:0] w_dat;
  logic [SEL_WIDTH-1:0]  w_sel;
  logic [2:0]            w_cti;
  logic [1:0]            w_bte;
  logic                  w_we;

  arb_rr #(
    .N (MASTERS)
  ) u_arb (
    .i_req  (m_cyc_i),
    .i_last (r_last),
    .o_gnt  (w_arb_gnt),
    .o_vld  (w_arb_vld)
  );

  assign w_held   = |(r_grant & m_cyc_i);
  assign w_stb_g  = |(r_grant & m_stb_i);
  assign w_term   = s_ack_i | s_err_i | s_rty_i;
  // A real termination in the expiry cycle wins over the watchdog.
  assign w_expire = WD_EN & (|r_grant) & (r_cnt == WD_LIM) & ~w_term;

  // AND-OR mux: the grant is one-hot or zero, so idle yields all zeros.
  always_comb begin
    w_adr = '0;
    w_dat = '0;
    w_sel = '0;
    w_cti = '0;
    w_bte = '0;
    w_we  = 1'b0;
    for (int i = 0; i < MASTERS; i++) begin
      w_adr = w_adr | (m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{r_grant[i]}});
      w_dat = w_dat | (m_dat_i[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{r_grant[i]}});
      w_sel = w_sel | (m_sel_i[i*SEL_WIDTH +: SEL_WIDTH] & {SEL_WIDTH{r_grant[i]}});
      w_cti = w_cti | (m_cti_i[i*3 +: 3] & {3{r_grant[i]}});
      w_bte = w_bte | (m_bte_i[i*2 +: 2] & {2{r_grant[i]}});
      w_we  = w_we  | (m_we_i[i] & r_grant[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_grant <= '0;
      r_last  <= LAST_INIT;
      r_cnt   <= '0;
    end else if (w_expire) begin
      r_grant <= '0;
      r_last  <= r_grant;
      r_cnt   <= '0;
    end else if (!w_held) begin
      r_grant <= w_arb_gnt;
      if (w_arb_vld) r_last <= w_arb_gnt;
      r_cnt   <= '0;
    end else if (w_term) begin
      r_cnt   <= '0;
    end else if (WD_EN && w_stb_g) begin
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  assign s_adr_o = w_adr;
  assign s_dat_o = w_dat;
  assign s_sel_o = w_sel;
  assign s_cti_o = w_cti;
  assign s_bte_o = w_bte;
  assign s_we_o  = w_we;
  assign s_cyc_o = w_held & ~w_expire;
  assign s_stb_o = w_stb_g & ~w_expire;

  assign m_dat_o = s_dat_i;
  assign m_ack_o = r_grant & {MASTERS{s_ack_i}};
  assign m_rty_o = r_grant & {MASTERS{s_rty_i}};
  assign m_err_o = (r_grant & {MASTERS{s_err_i}}) | (r_grant & {MASTERS{w_expire}});
  assign grant_o = r_grant;

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed bench for wb_arbiter_rr: two masters, watchdog at 8 stall cycles.
module tb_wb_arbiter_rr;

  localparam int M  = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW*M-1:0] m_adr;
  logic [DW*M-1:0] m_dat;
  logic [M-1:0]    m_cyc, m_stb, m_we;
  logic [SW*M-1:0] m_sel;
  logic [3*M-1:0]  m_cti;
  logic [2*M-1:0]  m_bte;
  logic [DW-1:0]   m_dat_o;
  logic [M-1:0]    m_ack_o, m_err_o, m_rty_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [SW-1:0]   s_sel_o;
  logic [2:0]      s_cti_o;
  logic [1:0]      s_bte_o;
  logic [DW-1:0]   s_dat;
  logic            s_ack, s_err, s_rty;
  logic [M-1:0]    grant;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_arbiter_rr #(
    .MASTERS(M), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_cyc_i(m_cyc), .m_stb_i(m_stb),
    .m_we_i(m_we), .m_sel_i(m_sel), .m_cti_i(m_cti), .m_bte_i(m_bte),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .grant_o(grant)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic cyc, input logic we,
                       input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                       input logic [2:0] cti);
    m_cyc[i]          = cyc;
    m_stb[i]          = cyc;
    m_we[i]           = we;
    m_adr[i*AW +: AW] = adr;
    m_dat[i*DW +: DW] = dat;
    m_cti[i*3 +: 3]   = cti;
    m_sel[i*SW +: SW] = cyc ? {SW{1'b1}} : {SW{1'b0}};
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    s_ack = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 3'b000);
    drive(1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 3'b000);
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      n_tests++;
      if (grant !== 2'b00 || s_cyc_o !== 1'b0 || m_ack_o !== 2'b00 || s_adr_o !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: grant=%b s_cyc=%b ack=%b adr=%h, want 00/0/00/0",
                 c, grant, s_cyc_o, m_ack_o, s_adr_o);
      end
    end
    rst = 1'b0;
    tick();
    #1;
    n_tests++;
    if (grant !== 2'b01 || m_ack_o !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_first_grant: grant=%b ack=%b, want 01/01", grant, m_ack_o);
    end
    s_ack = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    tick();
    #1;
    n_tests++;
    if (grant !== 2'b00 || s_cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: grant=%b s_cyc=%b, want 00/0", grant, s_cyc_o);
    end
  endtask

  task automatic test_single_read();
    drive(1, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 3'b000);
    #1;
    n_tests++;
    if (grant !== 2'b00 || s_cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL read_pre_grant: grant=%b s_cyc=%b, want 00/0", grant, s_cyc_o);
    end
    tick();
    #1;
    n_tests++;
    if (grant !== 2'b10 || s_adr_o !== 32'h0000_1000 || s_cyc_o !== 1'b1 || s_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL read_grant: grant=%b adr=%h cyc=%b we=%b, want 10/00001000/1/0",
               grant, s_adr_o, s_cyc_o, s_we_o);
    end
    tick();
    s_ack = 1'b1;
    s_dat = 32'hDEAD_BEEF;
    #1;
    n_tests++;
    if (m_ack_o !== 2'b10 || m_dat_o !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL read_ack: ack=%b dat=%h, want 10/deadbeef", m_ack_o, m_dat_o);
    end
    tick();
    s_ack = 1'b0;
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    tick();
    #1;
    n_tests++;
    if (grant !== 2'b00) begin
      n_fail++;
      $display("FAIL read_release: grant=%b, want 00", grant);
    end
  endtask

  task automatic test_round_robin();
    drive(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 3'b000);
    drive(1, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 3'b000);
    tick();
    s_ack = 1'b1;
    #1;
    n_tests++;
    if (grant !== 2'b01 || m_ack_o !== 2'b01 || s_adr_o !== 32'h0000_0040) begin
      n_fail++;
      $display("FAIL rr_first: grant=%b ack=%b adr=%h, want 01/01/00000040", grant, m_ack_o, s_adr_o);
    end
    tick();
    s_ack = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    #1;
    n_tests++;
    if (grant !== 2'b01 || s_cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_release_cycle: grant=%b s_cyc=%b, want 01/0", grant, s_cyc_o);
    end
    tick();
    s_ack = 1'b1;
    #1;
    n_tests++;
    if (grant !== 2'b10 || m_ack_o !== 2'b10 || s_adr_o !== 32'h0000_0080) begin
      n_fail++;
      $display("FAIL rr_handover: grant=%b ack=%b adr=%h, want 10/10/00000080", grant, m_ack_o, s_adr_o);
    end
    tick();
    s_ack = 1'b0;
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    tick();
    drive(0, 1'b1, 1'b0, 32'h0000_0044, 32'h0, 3'b000);
    drive(1, 1'b1, 1'b0, 32'h0000_0084, 32'h0, 3'b000);
    tick();
    #1;
    n_tests++;
    if (grant !== 2'b01) begin
      n_fail++;
      $display("FAIL rr_again: grant=%b, want 01", grant);
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    tick();
  endtask

  task automatic test_burst_atomic();
    logic [2:0] cti_seq [4];
    cti_seq[0] = 3'b010; cti_seq[1] = 3'b010; cti_seq[2] = 3'b010; cti_seq[3] = 3'b111;
    drive(0, 1'b1, 1'b1, 32'h0000_2000, 32'hA000_0000, cti_seq[0]);
    tick();
    for (int b = 0; b < 4; b++) begin
      drive(0, 1'b1, 1'b1, 32'h0000_2000 + 32'(4 * b), 32'hA000_0000 + 32'(b), cti_seq[b]);
      if (b == 1) drive(1, 1'b1, 1'b0, 32'h0000_3000, 32'h0, 3'b000);
      s_ack = 1'b1;
      #1;
      n_tests++;
      if (grant !== 2'b01 || m_ack_o !== 2'b01 || s_cti_o !== cti_seq[b] ||
          s_adr_o !== 32'h0000_2000 + 32'(4 * b) || s_dat_o !== 32'hA000_0000 + 32'(b) || s_we_o !== 1'b1) begin
        n_fail++;
        $display("FAIL burst_beat%0d: grant=%b ack=%b cti=%b adr=%h dat=%h we=%b", b,
                 grant, m_ack_o, s_cti_o, s_adr_o, s_dat_o, s_we_o);
      end
      tick();
    end
    s_ack = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    #1;
    n_tests++;
    if (grant !== 2'b01 || s_cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_end: grant=%b s_cyc=%b, want 01/0", grant, s_cyc_o);
    end
    tick();
    #1;
    n_tests++;
    if (grant !== 2'b10 || s_adr_o !== 32'h0000_3000) begin
      n_fail++;
      $display("FAIL burst_handover: grant=%b adr=%h, want 10/00003000", grant, s_adr_o);
    end
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    tick();
  endtask

  task automatic test_watchdog();
    logic [1:0] exp_err;
    logic       exp_cyc;
    drive(0, 1'b1, 1'b0, 32'h0000_4000, 32'h0, 3'b000);
    tick();
    drive(1, 1'b1, 1'b0, 32'h0000_5000, 32'h0, 3'b000);
    for (int k = 1; k <= 9; k++) begin
      exp_err = (k == 9) ? 2'b01 : 2'b00;
      exp_cyc = (k == 9) ? 1'b0 : 1'b1;
      #1;
      n_tests++;
      if (grant !== 2'b01 || m_err_o !== exp_err || s_cyc_o !== exp_cyc) begin
        n_fail++;
        $display("FAIL wd_stall%0d: grant=%b err=%b s_cyc=%b, want 01/%b/%b",
                 k, grant, m_err_o, s_cyc_o, exp_err, exp_cyc);
      end
      tick();
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    #1;
    n_tests++;
    if (grant !== 2'b00 || m_err_o !== 2'b00) begin
      n_fail++;
      $display("FAIL wd_release: grant=%b err=%b, want 00/00", grant, m_err_o);
    end
    tick();
    #1;
    n_tests++;
    if (grant !== 2'b10 || s_adr_o !== 32'h0000_5000) begin
      n_fail++;
      $display("FAIL wd_next_grant: grant=%b adr=%h, want 10/00005000", grant, s_adr_o);
    end
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    tick();
  endtask

  task automatic test_reset_mid_burst();
    drive(0, 1'b1, 1'b0, 32'h0000_6000, 32'h0, 3'b010);
    tick();
    for (int b = 0; b < 2; b++) begin
      s_ack = 1'b1;
      tick();
    end
    s_ack = 1'b0;
    rst   = 1'b1;
    #1;
    n_tests++;
    if (grant !== 2'b01 || s_cyc_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rstb_beat2: grant=%b s_cyc=%b, want 01/1", grant, s_cyc_o);
    end
    tick();
    rst = 1'b0;
    #1;
    n_tests++;
    if (grant !== 2'b00 || s_cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rstb_abort: grant=%b s_cyc=%b, want 00/0", grant, s_cyc_o);
    end
    tick();
    #1;
    n_tests++;
    if (grant !== 2'b01 || s_cyc_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rstb_regrant: grant=%b s_cyc=%b, want 01/1", grant, s_cyc_o);
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    tick();
  endtask

  initial begin
    rst   = 1'b1;
    m_adr = '0; m_dat = '0; m_cyc = '0; m_stb = '0; m_we = '0;
    m_sel = '0; m_cti = '0; m_bte = '0;
    s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_burst_atomic();
    test_watchdog();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: simulation did not reach the summary");
    $fatal(1, "simulation time limit");
  end

endmodule
